// File: rtl/seg_display_pkg.sv
// Shared types and helpers for the scanned 7-segment display.
// Segment codes are {g,f,e,d,c,b,a}, active high.
package seg_display_pkg;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
    logic [6:0] s;
    s = SEG_BLANK;
    unique case (nibble)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter.
// One shift per cycle, followed by a single LOAD cycle that flags done.
module bin2bcd_seq
  import seg_display_pkg::*;
#(
  parameter int VALUE_W = 14,
  parameter int NIBBLES = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [VALUE_W-1:0]     value,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   bcd
);

  localparam int CNT_W = $clog2(VALUE_W + 1);

  state_t               state;
  state_t               state_nxt;
  logic [VALUE_W-1:0]   sh;
  logic [4*NIBBLES-1:0] acc;
  logic [4*NIBBLES-1:0] acc_adj;
  logic [CNT_W-1:0]     cnt;

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < NIBBLES; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (cnt == CNT_W'(VALUE_W - 1)) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      sh    <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      unique case (state)
        IDLE: begin
          if (start) begin
            sh  <= value;
            acc <= '0;
            cnt <= '0;
          end
        end
        CONV: begin
          acc <= {acc_adj[4*NIBBLES-2:0], sh[VALUE_W-1]};
          sh  <= sh << 1;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done = (state == LOAD);
  assign bcd  = acc;

endmodule

// File: rtl/scan_seg_display.sv
// Time-multiplexed multi-digit 7-segment driver with BCD conversion,
// leading-zero blanking and overflow dashes.
module scan_seg_display
  import seg_display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int VALUE_W  = 14,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_valid,
  output logic               busy,
  output logic               overflow,
  output logic [6:0]         seg,
  output logic [DIGITS-1:0]  an
);

  localparam int NIBBLES = DIGITS + 2;
  localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                 done;
  logic [4*NIBBLES-1:0] bcd;
  logic [4*DIGITS-1:0]  digits;
  logic [DIV_W-1:0]     div;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic                 slot_end;
  logic [6:0]           seg_nxt;
  logic [3:0]           nib;
  logic                 lz;

  bin2bcd_seq #(
    .VALUE_W (VALUE_W),
    .NIBBLES (NIBBLES)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (value_valid),
    .value (value),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  assign slot_end = (div == DIV_W'(SCAN_DIV - 1));
  assign idx_nxt  = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;

  // Walk from the top digit down so lz tracks "everything from here up is 0".
  always_comb begin
    seg_nxt = SEG_BLANK;
    nib     = 4'd0;
    lz      = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz = lz & (digits[4*i +: 4] == 4'd0);
      if (i == int'(idx_nxt)) begin
        nib = digits[4*i +: 4];
        if (overflow)
          seg_nxt = SEG_DASH;
        else if (BLANK_LZ != 0 && i > 0 && lz)
          seg_nxt = SEG_BLANK;
        else
          seg_nxt = seg7_encode(nib);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits   <= '0;
      overflow <= 1'b0;
    end else if (done) begin
      digits   <= bcd[4*DIGITS-1:0];
      overflow <= |bcd[4*NIBBLES-1:4*DIGITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
      an  <= DIGITS'(1);
      seg <= 7'h3F;
    end else if (slot_end) begin
      div <= '0;
      idx <= idx_nxt;
      an  <= DIGITS'(1) << idx_nxt;
      seg <= seg_nxt;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: tb/tb_scan_seg_display.sv
// Bench for scan_seg_display: directed scenarios plus random values
// compared against a decimal-arithmetic display model.
module tb_scan_seg_display;

  localparam int DIGITS   = 4;
  localparam int VALUE_W  = 14;
  localparam int SCAN_DIV = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [VALUE_W-1:0] value;
  logic               value_valid;
  logic               busy;
  logic               overflow;
  logic [6:0]         seg;
  logic [DIGITS-1:0]  an;

  int checks   = 0;
  int failures = 0;

  logic [6:0] enc [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  scan_seg_display #(
    .DIGITS   (DIGITS),
    .VALUE_W  (VALUE_W),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_LZ (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .value_valid (value_valid),
    .busy        (busy),
    .overflow    (overflow),
    .seg         (seg),
    .an          (an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r = r * 10;
    return r;
  endfunction

  function automatic int exp_seg(input int v, input int i);
    if (v >= pow10(DIGITS)) return 'h40;
    if (i > 0 && v < pow10(i)) return 'h00;
    return int'(enc[(v / pow10(i)) % 10]);
  endfunction

  task automatic convert(input int v);
    int n = 0;
    value       = VALUE_W'(v);
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk("busy_len", n, VALUE_W + 1);
  endtask

  task automatic check_scan(input int v, input string tag);
    int slot;
    for (int k = 0; k < 2 * DIGITS * SCAN_DIV; k++) tick();
    chk({tag, "_ovf"}, int'(overflow), int'(v >= pow10(DIGITS)));
    for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
      chk({tag, "_onehot"}, int'($onehot(an)), 1);
      slot = 0;
      for (int i = 0; i < DIGITS; i++) if (an[i]) slot = i;
      chk({tag, "_seg"}, int'(seg), exp_seg(v, slot));
      tick();
    end
  endtask

  initial begin
    int v;
    rst         = 1'b1;
    value       = '0;
    value_valid = 1'b0;
    tick();
    tick();
    chk("rst_an", int'(an), 1);
    chk("rst_seg", int'(seg), 'h3F);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("scan_hold", int'(an), 1);
    tick();
    chk("scan_step", int'(an), 2);

    convert(1234);
    check_scan(1234, "v1234");
    convert(7);
    check_scan(7, "v7");
    convert(10000);
    check_scan(10000, "v10000");
    convert(905);
    check_scan(905, "v905");

    value       = VALUE_W'(1234);
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    tick();
    tick();
    value       = VALUE_W'(42);
    value_valid = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    value_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("drop_busy", int'(busy), 0);
    check_scan(1234, "drop");

    value       = VALUE_W'(9999);
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("abort_busy_pre", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_an", int'(an), 1);
    chk("abort_seg", int'(seg), 'h3F);
    chk("abort_ovf", int'(overflow), 0);
    check_scan(0, "abort");

    for (int r = 0; r < 12; r++) begin
      v = int'($urandom_range(0, (1 << VALUE_W) - 1));
      if (r < 4) v = v % 100;
      convert(v);
      check_scan(v, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
